// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins contention; a saturating starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam logic [2:0] SMAX     = 3'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t     state, state_nx;
  acc_t       acc_q;
  logic [2:0] lat_cnt;
  logic [2:0] starve_cnt;
  logic       grant;
  logic       gnt_d;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gnt_d    = 1'b0;
    case (state)
      IDLE: begin
        // data has priority unless fetch has waited out STARVE_MAX data grants
        if (d_req && (!if_req || starve_cnt != SMAX)) begin
          grant = 1'b1;
          gnt_d = 1'b1;
        end else if (if_req) begin
          grant = 1'b1;
        end
        if (grant) state_nx = ISSUE;
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_q      <= '0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 3'd0;
      grant_id   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        grant_id <= gnt_d;
        if (gnt_d) begin
          acc_q <= '{we: d_we, addr: d_addr, wdata: d_wdata};
          if (if_req && starve_cnt < SMAX) starve_cnt <= starve_cnt + 3'd1;
        end else begin
          acc_q      <= '{we: 1'b0, addr: if_addr, wdata: '0};
          starve_cnt <= 3'd0;
        end
      end
      if (state == ISSUE) lat_cnt <= LAT_INIT;
      if (state == WAIT) begin
        if (lat_cnt != 3'd0) begin
          lat_cnt <= lat_cnt - 3'd1;
        end else if (grant_id) begin
          if (!acc_q.we) d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & acc_q.we;
  assign mem_addr  = mem_en ? acc_q.addr  : '0;
  assign mem_wdata = mem_en ? acc_q.wdata : '0;
  assign if_ack    = (state == RESP) & ~grant_id;
  assign d_ack     = (state == RESP) &  grant_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiters with MEM_LAT 1..4, each with its own memory model.
module tb_mem_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       if_req, if_ack, d_req, d_we, d_ack;
  logic [N-1:0]       mem_en, mem_we, busy, grant_id;
  logic [N-1:0][7:0]  if_addr, d_addr, mem_addr;
  logic [N-1:0][15:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] init_word(logic [7:0] a);
    return (a == 8'h05) ? 16'h1234 : {8'hA5, a};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [15:0]  wmem [256];
    logic [255:0] wv;
    logic [15:0]  rpipe [4];

    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(g + 1), .STARVE_MAX(3)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .grant_id(grant_id[g])
    );

    // read data appears exactly g+1 cycles after the mem_en cycle
    always_ff @(posedge clk) begin
      if (rst) wv <= '0;
      else if (mem_en[g] && mem_we[g]) begin
        wmem[mem_addr[g]] <= mem_wdata[g];
        wv[mem_addr[g]]   <= 1'b1;
      end
      rpipe[0] <= (mem_en[g] && !mem_we[g])
                  ? (wv[mem_addr[g]] ? wmem[mem_addr[g]] : init_word(mem_addr[g]))
                  : 16'hDEAD;
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[g] = rpipe[g];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one access on instance k, started in an IDLE cycle; returns timing relative to that cycle
  task automatic access(input int k, input bit is_d, input bit we, input logic [7:0] a,
                        input logic [15:0] wd, output int ack_cyc, output int busy_n,
                        output int en_cyc, output logic en_we, output logic [7:0] en_a,
                        output logic [15:0] en_wd, output logic [15:0] rd, output int bad);
    ack_cyc = -1; busy_n = 0; en_cyc = -1; bad = 0;
    en_we = 1'b0; en_a = '0; en_wd = '0; rd = '0;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = a;
    end
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (busy[k]) busy_n++;
      if (mem_en[k]) begin
        if (en_cyc >= 0) bad++;
        en_cyc = c; en_we = mem_we[k]; en_a = mem_addr[k]; en_wd = mem_wdata[k];
      end else if (mem_we[k] || mem_addr[k] != 8'h0 || mem_wdata[k] != 16'h0) bad++;
      if (is_d ? if_ack[k] : d_ack[k]) bad++;
      if (is_d ? d_ack[k] : if_ack[k]) begin
        ack_cyc = c;
        rd = is_d ? d_rdata[k] : if_rdata[k];
        if_req[k] = 1'b0; d_req[k] = 1'b0;
        break;
      end
    end
    cyc();
    if (if_ack[k] || d_ack[k] || busy[k]) bad++;
  endtask

  int ack_c, busy_c, en_c, bad, ng;
  logic en_we_o;
  logic [7:0] en_a_o;
  logic [15:0] en_wd_o, rd_o;
  int gnt [8];
  int stv [8];
  logic [15:0] pre_store;

  initial begin
    rst = 1'b1;
    if_req = '0; d_req = '0; d_we = '0; if_addr = '0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    cyc();
    for (int k = 0; k < N; k++)
      chk($sformatf("reset_outs%0d", k),
          {busy[k], mem_en[k], mem_we[k], if_ack[k], d_ack[k], grant_id[k],
           |mem_addr[k], |mem_wdata[k], |if_rdata[k], |d_rdata[k]}, 32'h0);
    rst = 1'b0;
    cyc();

    // single fetch, MEM_LAT=1
    access(0, 1'b0, 1'b0, 8'h05, 16'h0, ack_c, busy_c, en_c, en_we_o, en_a_o, en_wd_o, rd_o, bad);
    chk("fetch_en_cyc", en_c, 1);
    chk("fetch_addr", en_a_o, 8'h05);
    chk("fetch_we", en_we_o, 1'b0);
    chk("fetch_ack_cyc", ack_c, 3);
    chk("fetch_rdata", rd_o, 16'h1234);
    chk("fetch_busy", busy_c, 3);
    chk("fetch_protocol", bad, 0);

    // contention: both requesting, data re-requests after each ack
    ng = 0;
    d_we[0] = 1'b0; d_addr[0] = 8'h20; if_addr[0] = 8'h07;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      cyc();
      if (mem_en[0] && ng < 8) begin
        gnt[ng] = grant_id[0];
        stv[ng] = g_dut[0].u_dut.starve_cnt;
        ng++;
      end
      if (if_ack[0]) if_req[0] = 1'b0;
      if (d_ack[0] && ng >= 5) begin
        d_req[0] = 1'b0;
        break;
      end
    end
    cyc();
    chk("cont_ngrants", ng, 5);
    chk("cont_order", {gnt[0][0], gnt[1][0], gnt[2][0], gnt[3][0], gnt[4][0]}, 5'b11101);
    chk("cont_starve_pre", stv[2], 3);
    chk("cont_starve_fetch", stv[3], 0);
    chk("cont_starve_last", stv[4], 0);
    chk("cont_if_rdata", if_rdata[0], 16'hA507);
    chk("cont_d_rdata", d_rdata[0], 16'hA520);

    // store then load
    pre_store = 16'hA520;
    access(0, 1'b1, 1'b1, 8'h10, 16'hBEEF, ack_c, busy_c, en_c, en_we_o, en_a_o, en_wd_o, rd_o, bad);
    chk("store_we", en_we_o, 1'b1);
    chk("store_addr", en_a_o, 8'h10);
    chk("store_wdata", en_wd_o, 16'hBEEF);
    chk("store_ack_cyc", ack_c, 3);
    chk("store_keeps_rdata", rd_o, pre_store);
    chk("store_protocol", bad, 0);
    access(0, 1'b1, 1'b0, 8'h10, 16'h0, ack_c, busy_c, en_c, en_we_o, en_a_o, en_wd_o, rd_o, bad);
    chk("load_we", en_we_o, 1'b0);
    chk("load_rdata", rd_o, 16'hBEEF);
    chk("load_protocol", bad, 0);

    // latency sweep
    for (int k = 0; k < N; k++) begin
      access(k, 1'b1, 1'b0, 8'(8'h30 + k), 16'h0, ack_c, busy_c, en_c, en_we_o, en_a_o, en_wd_o, rd_o, bad);
      chk($sformatf("lat%0d_en_cyc", k + 1), en_c, 1);
      chk($sformatf("lat%0d_ack_cyc", k + 1), ack_c, k + 3);
      chk($sformatf("lat%0d_busy", k + 1), busy_c, k + 3);
      chk($sformatf("lat%0d_rdata", k + 1), rd_o, {8'hA5, 8'(8'h30 + k)});
      chk($sformatf("lat%0d_protocol", k + 1), bad, 0);
    end

    // reset during WAIT on the MEM_LAT=3 instance
    d_we[2] = 1'b0; d_addr[2] = 8'h40; d_req[2] = 1'b1;
    cyc();
    chk("rst_mid_issue", mem_en[2], 1'b1);
    cyc();
    chk("rst_mid_wait", {busy[2], mem_en[2]}, 2'b10);
    rst = 1'b1; d_req[2] = 1'b0;
    cyc();
    chk("rst_mid_outs",
        {busy[2], mem_en[2], mem_we[2], if_ack[2], d_ack[2], grant_id[2],
         |mem_addr[2], |mem_wdata[2], |if_rdata[2], |d_rdata[2]}, 32'h0);
    chk("rst_mid_starve", g_dut[2].u_dut.starve_cnt, 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (d_ack[2] || if_ack[2] || busy[2]) bad++;
    end
    chk("rst_mid_no_ack", bad, 0);
    access(2, 1'b0, 1'b0, 8'h05, 16'h0, ack_c, busy_c, en_c, en_we_o, en_a_o, en_wd_o, rd_o, bad);
    chk("post_rst_fetch_ack", ack_c, 5);
    chk("post_rst_fetch_rdata", rd_o, 16'h1234);
    chk("post_rst_protocol", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
